flash_scan_ctrl: RTL and testbench

- Upstream request sequencer for the SPI flash controller. Replaces the free-running address counter on the board top level.
- Walks flash addresses from START_ADDR to END_ADDR in steps of STEP and issues one read per address.
- Waits for each transaction to complete, latches the returned word, and holds it for HOLD_CYCLES so the 7-segment driver can display it.
- Detects stalled transactions with a timeout and flags them.

---
 rtl/flash_pkg.sv | 27 ++
 rtl/flash_timer.sv | 27 ++
 rtl/flash_scan_ctrl.sv | 134 +++++++++++++
 tb/tb_flash_scan_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/flash_pkg.sv
// Shared definitions for the flash scan sequencer: widths, FSM encoding and
// the helper that turns a cycle budget into a down-counter preload.
package flash_pkg;

    localparam int unsigned FLASH_ADDR_W = 24;
    localparam int unsigned FLASH_DATA_W = 32;
    localparam int unsigned HOLD_CNT_W   = 32;
    localparam int unsigned TMO_CNT_W    = 16;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        WAIT_DONE,
        HOLD,
        NEXT
    } flash_state_t;

    // A timer loaded with N-1 reaches zero on its Nth enabled cycle.
    function automatic logic [31:0] cycles_to_load(input int unsigned cycles);
        if (cycles == 0) begin
            return '0;
        end
        return 32'(cycles - 1);
    endfunction

endpackage

// File: rtl/flash_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module flash_timer #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/flash_scan_ctrl.sv
// Request sequencer: walks flash addresses, issues one read per address,
// holds each returned word for display and flags stalled transactions.
module flash_scan_ctrl
    import flash_pkg::*;
#(
    parameter int unsigned       ADDR_W         = FLASH_ADDR_W,
    parameter logic [ADDR_W-1:0] START_ADDR     = '0,
    parameter logic [ADDR_W-1:0] END_ADDR       = ADDR_W'(32'h0000_00FC),
    parameter int unsigned       STEP           = 4,
    parameter int unsigned       HOLD_CYCLES    = 25000000,
    parameter int unsigned       TIMEOUT_CYCLES = 65535
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    run,
    input  logic                    flash_busy,
    input  logic [FLASH_DATA_W-1:0] flash_rdata,
    output logic                    flash_en,
    output logic                    flash_write,
    output logic [ADDR_W-1:0]       flash_addr,
    output logic [FLASH_DATA_W-1:0] display_data,
    output logic                    data_valid,
    output logic                    timeout_err,
    output logic                    wrap_pulse
);

    localparam logic [HOLD_CNT_W-1:0] HOLD_LOAD = HOLD_CNT_W'(cycles_to_load(HOLD_CYCLES));
    localparam logic [TMO_CNT_W-1:0]  TMO_LOAD  = TMO_CNT_W'(cycles_to_load(TIMEOUT_CYCLES));
    localparam logic [ADDR_W-1:0]     ADDR_STEP = ADDR_W'(STEP);

    flash_state_t state;

    logic hold_load;
    logic hold_en;
    logic hold_done;
    logic tmo_load;
    logic tmo_en;
    logic tmo_done;

    // The timeout budget is shared by WAIT_ACK and WAIT_DONE together.
    assign tmo_load  = (state == ISSUE);
    assign tmo_en    = (state == WAIT_ACK) || (state == WAIT_DONE);
    assign hold_load = (state == WAIT_DONE) && !flash_busy;
    assign hold_en   = (state == HOLD);

    flash_timer #(
        .W (HOLD_CNT_W)
    ) u_hold_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (hold_load),
        .load_val (HOLD_LOAD),
        .en       (hold_en),
        .done     (hold_done)
    );

    flash_timer #(
        .W (TMO_CNT_W)
    ) u_tmo_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmo_load),
        .load_val (TMO_LOAD),
        .en       (tmo_en),
        .done     (tmo_done)
    );

    assign flash_write = 1'b0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            flash_en     <= 1'b0;
            flash_addr   <= START_ADDR;
            display_data <= '0;
            data_valid   <= 1'b0;
            timeout_err  <= 1'b0;
            wrap_pulse   <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            wrap_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (run && !flash_busy) begin
                        flash_en <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (flash_busy) begin
                        flash_en <= 1'b0;
                        state    <= WAIT_DONE;
                    end else if (tmo_done) begin
                        flash_en    <= 1'b0;
                        timeout_err <= 1'b1;
                        state       <= NEXT;
                    end
                end
                WAIT_DONE: begin
                    if (!flash_busy) begin
                        display_data <= flash_rdata;
                        data_valid   <= 1'b1;
                        state        <= HOLD;
                    end else if (tmo_done) begin
                        timeout_err <= 1'b1;
                        state       <= NEXT;
                    end
                end
                HOLD: begin
                    if (hold_done) begin
                        state <= NEXT;
                    end
                end
                NEXT: begin
                    if (flash_addr == END_ADDR) begin
                        flash_addr <= START_ADDR;
                        wrap_pulse <= 1'b1;
                    end else begin
                        flash_addr <= flash_addr + ADDR_STEP;
                    end
                    state <= IDLE;
                end
                default: begin
                    flash_en <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flash_scan_ctrl.sv
// Directed bench for flash_scan_ctrl: a cycle-by-cycle vector table for the
// normal scan and wrap, plus hand sequences for timeout, run drop and reset.
module tb_flash_scan_ctrl;

    localparam logic [31:0] FILL = 32'h1111_1111;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        flash_busy;
    logic [31:0] flash_rdata;
    logic        flash_en;
    logic        flash_write;
    logic [23:0] flash_addr;
    logic [31:0] display_data;
    logic        data_valid;
    logic        timeout_err;
    logic        wrap_pulse;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    flash_scan_ctrl #(
        .ADDR_W         (24),
        .START_ADDR     (24'h000000),
        .END_ADDR       (24'h000008),
        .STEP           (4),
        .HOLD_CYCLES    (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .run          (run),
        .flash_busy   (flash_busy),
        .flash_rdata  (flash_rdata),
        .flash_en     (flash_en),
        .flash_write  (flash_write),
        .flash_addr   (flash_addr),
        .display_data (display_data),
        .data_valid   (data_valid),
        .timeout_err  (timeout_err),
        .wrap_pulse   (wrap_pulse)
    );

    typedef struct {
        logic        rst;
        logic        run;
        logic        busy;
        logic [31:0] rdata;
        logic        en;
        logic [23:0] addr;
        logic [31:0] disp;
        logic        dv;
        logic        wrap;
        logic        tmo;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after an edge; outputs are sampled there too.
    task automatic step(input logic r, input logic rn, input logic b, input logic [31:0] d);
        reset       = r;
        run         = rn;
        flash_busy  = b;
        flash_rdata = d;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic rn, input logic b, input logic [31:0] d,
                       input logic en, input logic [23:0] addr, input logic [31:0] disp,
                       input logic dv, input logic wrap, input logic tmo);
        vec_t v;
        v.rst = r;  v.run = rn;  v.busy = b;  v.rdata = d;
        v.en = en;  v.addr = addr;  v.disp = disp;
        v.dv = dv;  v.wrap = wrap;  v.tmo = tmo;
        vq.push_back(v);
    endtask

    initial begin
        int en_hi;
        int dv_cnt;
        reset       = 1'b1;
        run         = 1'b0;
        flash_busy  = 1'b0;
        flash_rdata = '0;

        // Normal scan 0 -> 4 -> 8 -> wrap to 0, HOLD_CYCLES=4.
        add(1, 0, 0, FILL,         0, 24'h0, 32'h0,         0, 0, 0);
        add(0, 1, 0, FILL,         1, 24'h0, 32'h0,         0, 0, 0);
        add(0, 1, 0, FILL,         1, 24'h0, 32'h0,         0, 0, 0);
        add(0, 1, 1, FILL,         0, 24'h0, 32'h0,         0, 0, 0);
        for (int i = 0; i < 4; i++)
            add(0, 1, 1, FILL,     0, 24'h0, 32'h0,         0, 0, 0);
        add(0, 1, 0, 32'hDEADBEEF, 0, 24'h0, 32'hDEADBEEF,  1, 0, 0);
        for (int i = 0; i < 4; i++)
            add(0, 1, 0, FILL,     0, 24'h0, 32'hDEADBEEF,  0, 0, 0);
        add(0, 1, 0, FILL,         0, 24'h4, 32'hDEADBEEF,  0, 0, 0);
        add(0, 1, 0, FILL,         1, 24'h4, 32'hDEADBEEF,  0, 0, 0);
        add(0, 1, 0, FILL,         1, 24'h4, 32'hDEADBEEF,  0, 0, 0);
        add(0, 1, 1, FILL,         0, 24'h4, 32'hDEADBEEF,  0, 0, 0);
        add(0, 1, 0, 32'hCAFEF00D, 0, 24'h4, 32'hCAFEF00D,  1, 0, 0);
        for (int i = 0; i < 4; i++)
            add(0, 1, 0, FILL,     0, 24'h4, 32'hCAFEF00D,  0, 0, 0);
        add(0, 1, 0, FILL,         0, 24'h8, 32'hCAFEF00D,  0, 0, 0);
        add(0, 1, 0, FILL,         1, 24'h8, 32'hCAFEF00D,  0, 0, 0);
        add(0, 1, 0, FILL,         1, 24'h8, 32'hCAFEF00D,  0, 0, 0);
        add(0, 1, 1, FILL,         0, 24'h8, 32'hCAFEF00D,  0, 0, 0);
        add(0, 1, 0, 32'h12345678, 0, 24'h8, 32'h12345678,  1, 0, 0);
        for (int i = 0; i < 4; i++)
            add(0, 1, 0, FILL,     0, 24'h8, 32'h12345678,  0, 0, 0);
        add(0, 1, 0, FILL,         0, 24'h0, 32'h12345678,  0, 1, 0);
        add(0, 1, 0, FILL,         1, 24'h0, 32'h12345678,  0, 0, 0);

        foreach (vq[i]) begin
            step(vq[i].rst, vq[i].run, vq[i].busy, vq[i].rdata);
            chk($sformatf("v%0d flash_en", i),     32'(flash_en),    32'(vq[i].en));
            chk($sformatf("v%0d flash_addr", i),   32'(flash_addr),  32'(vq[i].addr));
            chk($sformatf("v%0d display_data", i), display_data,     vq[i].disp);
            chk($sformatf("v%0d data_valid", i),   32'(data_valid),  32'(vq[i].dv));
            chk($sformatf("v%0d wrap_pulse", i),   32'(wrap_pulse),  32'(vq[i].wrap));
            chk($sformatf("v%0d timeout_err", i),  32'(timeout_err), 32'(vq[i].tmo));
            chk($sformatf("v%0d flash_write", i),  32'(flash_write), 32'h0);
        end

        // Busy never rises: ISSUE + 16 WAIT_ACK cycles of flash_en, then NEXT.
        step(1, 0, 0, FILL);
        chk("tmo reset timeout_err", 32'(timeout_err), 32'h0);
        en_hi  = 0;
        dv_cnt = 0;
        for (int c = 0; c < 60; c++) begin
            step(0, 1, 0, FILL);
            if (data_valid) dv_cnt++;
            if (flash_en) en_hi++;
            else if (en_hi > 0) break;
        end
        chk("tmo flash_en cycles", 32'(en_hi), 32'd17);
        chk("tmo timeout_err set", 32'(timeout_err), 32'h1);
        chk("tmo no data_valid", 32'(dv_cnt), 32'h0);
        chk("tmo display_data", display_data, 32'h0);
        chk("tmo addr held", 32'(flash_addr), 32'h0);
        step(0, 1, 0, FILL);
        chk("tmo addr advanced", 32'(flash_addr), 32'h4);
        step(0, 1, 0, FILL);
        chk("tmo next request", 32'(flash_en), 32'h1);
        chk("tmo next addr", 32'(flash_addr), 32'h4);
        chk("tmo sticky", 32'(timeout_err), 32'h1);

        // run dropped during WAIT_DONE: finish, hold, advance, park.
        step(1, 0, 0, FILL);
        chk("rundrop reset clears timeout_err", 32'(timeout_err), 32'h0);
        step(0, 1, 0, FILL);
        step(0, 1, 0, FILL);
        step(0, 1, 1, FILL);
        step(0, 0, 1, FILL);
        chk("rundrop still waiting", 32'(data_valid), 32'h0);
        step(0, 0, 0, 32'hA5A5A5A5);
        chk("rundrop data_valid", 32'(data_valid), 32'h1);
        chk("rundrop display_data", display_data, 32'hA5A5A5A5);
        en_hi  = 0;
        dv_cnt = 0;
        for (int c = 0; c < 15; c++) begin
            step(0, 0, 0, FILL);
            if (flash_en) en_hi++;
            if (data_valid) dv_cnt++;
        end
        chk("rundrop no request", 32'(en_hi), 32'h0);
        chk("rundrop no extra data_valid", 32'(dv_cnt), 32'h0);
        chk("rundrop addr advanced", 32'(flash_addr), 32'h4);
        chk("rundrop display held", display_data, 32'hA5A5A5A5);

        // Reset in WAIT_DONE while rdata would otherwise be latched.
        step(0, 1, 0, FILL);
        step(0, 1, 0, FILL);
        step(0, 1, 1, FILL);
        step(1, 1, 0, 32'hFFFFFFFF);
        chk("rst flash_en", 32'(flash_en), 32'h0);
        chk("rst flash_addr", 32'(flash_addr), 32'h0);
        chk("rst display_data", display_data, 32'h0);
        chk("rst data_valid", 32'(data_valid), 32'h0);
        step(0, 0, 0, 32'hFFFFFFFF);
        chk("rst after data_valid", 32'(data_valid), 32'h0);
        chk("rst after display_data", display_data, 32'h0);

        // Reset in WAIT_ACK drops the active request.
        step(0, 1, 0, FILL);
        step(0, 1, 0, FILL);
        chk("rstack flash_en high", 32'(flash_en), 32'h1);
        step(1, 1, 0, FILL);
        chk("rstack flash_en dropped", 32'(flash_en), 32'h0);

        // Controller busy at reset release: wait for it, then one request.
        step(1, 1, 1, FILL);
        en_hi = 0;
        for (int c = 0; c < 5; c++) begin
            step(0, 1, 1, FILL);
            if (flash_en) en_hi++;
        end
        chk("busyidle no request", 32'(en_hi), 32'h0);
        step(0, 1, 0, FILL);
        chk("busyidle request", 32'(flash_en), 32'h1);
        chk("busyidle addr", 32'(flash_addr), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
